sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Round-robin arbiter sharing one toggle-handshake SDRAM controller port among several requesters, each speaking the same req/ack toggle protocol as a native controller port. It sits between the port testers (or system clients) and a single controller port. This lets stress configurations load one controller port with more clients than it has. A watchdog releases a requester whose access the controller never completes, and records which port stalled.

## Interface
Parameters:
- `PORTS`, 4: number of requesters (2..8).
- `ADDRW`, 22: word address width, bits [ADDRW:1].
- `DATAW`, 16: data width.
- `TIMEOUT`, 255: cycles in WAIT before the watchdog fires (1..65535).

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `req`  in  PORTS: per-port request toggle. Port i is pending while `req[i] != ack[i]`.
- `ack`  out  PORTS: per-port acknowledge toggle.
- `we`  in  PORTS: per-port write enable, sampled at grant.
- `addr`  in  PORTS*ADDRW: packed per-port addresses; port i is slice i.
- `din`  in  PORTS*DATAW: packed per-port write data.
- `dout`  out  PORTS*DATAW: packed per-port read data, registered.
- `mem_req`  out  1: toggle to the controller.
- `mem_ack`  in  1: toggle from the controller.
- `mem_we`, `mem_addr`, `mem_din`  out: latched command for the controller.
- `mem_dout`  in  DATAW: controller read data.
- `busy`  out  1: high in any state other than IDLE.
- `grant`  out  3: index of the current or last-granted port.
- `timeout_err`  out  1: sticky watchdog flag.
- `timeout_port`  out  3: port that caused the first timeout.

## Operation
States: IDLE, WAIT, DRAIN.

IDLE:
- `pending = req ^ ack`.
- If pending is non-zero, pick the first set bit scanning upward from `rr_ptr` with wrap.
- Latch the winner's `we`, address slice and data slice into `mem_we`, `mem_addr`, `mem_din`.
- Set `grant`, toggle `mem_req`, clear the watchdog counter, go to WAIT.

WAIT:
- If `mem_ack == mem_req`:
  - For a read, latch `mem_dout` into `dout` slice `grant`.
  - For a write, leave `dout` unchanged.
  - Toggle `ack[grant]`, set `rr_ptr <= (grant+1) mod PORTS`, go to IDLE.
- Otherwise, if the counter reaches TIMEOUT:
  - Toggle `ack[grant]` and leave `dout` unchanged.
  - Set `timeout_err`. Load `timeout_port` only if `timeout_err` was previously clear.
  - Advance `rr_ptr` and go to DRAIN.
- The counter is 16 bits and saturates.

DRAIN:
- Wait, with no limit, for `mem_ack == mem_req`, then go to IDLE.
- A late `mem_dout` is discarded.

General rules:
- Exactly one outstanding controller access at any time.
- `mem_*` command outputs are stable from the issue edge until the next issue.
- A requester that toggles `req` again while pending is violating the protocol. The arbiter still treats it as one pending access (XOR semantics).
- A `req` toggle on the same edge that `ack[i]` toggles becomes a new pending request, visible the next cycle.
- Ports other than `grant` may toggle `req` during WAIT; they are queued, not lost.

## Timing
- Reset (synchronous, `reset_n` low at a rising edge):
  - `ack = 0`, `dout = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_din = 0`.
  - `grant = 0`, `rr_ptr = 0`, `busy = 0`, `timeout_err = 0`, `timeout_port = 0`, state IDLE.
  - `mem_req <= mem_ack`, so the controller sees no pending access.
  - Reset mid-access abandons the access with no ack toggle; requesters must be reset together with the arbiter.
- Latency, counted from the edge where `req[i]` toggles (edge 0) with the arbiter idle:
  - `mem_req` toggles at edge 1.
  - If `mem_ack` toggles at edge N, `ack[i]` toggles and `dout` is valid at edge N+1.
  - A back-to-back grant to another pending port issues at edge N+2.
- Watchdog: `ack[i]` toggles at edge 1+TIMEOUT+1 if `mem_ack` never answers.
- `busy` is registered; it rises at edge 1 and falls on the edge entering IDLE.

## Structure
- Package `sdram_arb_pkg`:
  - state enum `arb_state_t` (IDLE, WAIT, DRAIN);
  - localparam `ARB_IDXW = 3`;
  - a function to extract a packed slice.
- Sub-module `rr_pick #(N)`: combinational rotating-priority encoder. Inputs `pending[N]` and `ptr`; outputs `found` and `idx`. It is reused by future schedulers.
- The top level holds the FSM, command latches, watchdog counter and the per-port `ack`/`dout` registers.

## Test plan
- **Single read:** PORTS=4, port 2 toggles `req` with `we=0`, addr 0x1234; the controller model acks 6 cycles later with data 0xBEEF. Then:
  - `mem_req` toggles at edge 1 with `mem_addr=0x1234`;
  - `ack[2]` toggles at edge 8;
  - `dout` slice 2 = 0xBEEF.
- **Fairness:** all 4 ports toggle `req` on the same edge, `rr_ptr=0`. Grant order must be 0,1,2,3. Then ports 0 and 3 re-request during port 3's access, and the next grants must be 0 then 3.
- **Write:** port 1 writes 0x55AA to addr 0x3FFFFF.
  - `mem_we=1`, `mem_din=0x55AA`, `mem_addr=0x3FFFFF` at issue.
  - `dout` slice 1 unchanged after the ack.
- **Watchdog:** TIMEOUT=10, the controller never acks port 3. Then:
  - `ack[3]` toggles at edge 12;
  - `timeout_err=1`, `timeout_port=3`;
  - a later request from port 0 is not issued until `mem_ack` finally toggles.
- **Reset:** `reset_n` asserted with `mem_ack=1`, then a port 0 request. `mem_req` must equal 1 after reset, and the first issue toggles it to 0.
- **Reset mid-access:** `reset_n` asserted mid-WAIT. All outputs return to their reset values, and no `ack` toggle occurs.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types, widths and slice helper for the SDRAM port arbiter
package sdram_arb_pkg;

    localparam int ARB_IDXW = 3;
    localparam int WDOG_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    // Bit offset of field idx in a vector of w-bit packed fields; used as a shift
    // amount so a slice can be pulled out or replaced without a wide index.
    function automatic int slice_base(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// rtl/sdram_port_arbiter_rr_pick.sv - rotating-priority encoder, first set bit at or above ptr with wrap
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        pending,
    input  logic [ARB_IDXW-1:0] ptr,
    output logic                found,
    output logic [ARB_IDXW-1:0] idx
);

    logic [N-1:0]        rot;
    logic [ARB_IDXW:0]   sel;
    logic [ARB_IDXW:0]   sum;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then map back to a port index.
    always_comb begin
        rot   = N'({pending, pending} >> ptr);
        found = |pending;
        sel   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sel = (ARB_IDXW + 1)'(j);
            end
        end
        sum = {1'b0, ptr} + sel;
        if (sum >= (ARB_IDXW + 1)'(N)) begin
            sum = sum - (ARB_IDXW + 1)'(N);
        end
        idx = sum[ARB_IDXW-1:0];
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin sharing of one toggle-handshake controller port with watchdog
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int PORTS   = 4,
    parameter int ADDRW   = 22,
    parameter int DATAW   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PORTS-1:0]         req,
    output logic [PORTS-1:0]         ack,
    input  logic [PORTS-1:0]         we,
    input  logic [PORTS*ADDRW-1:0]   addr,
    input  logic [PORTS*DATAW-1:0]   din,
    output logic [PORTS*DATAW-1:0]   dout,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic                     mem_we,
    output logic [ADDRW-1:0]         mem_addr,
    output logic [DATAW-1:0]         mem_din,
    input  logic [DATAW-1:0]         mem_dout,
    output logic                     busy,
    output logic [ARB_IDXW-1:0]      grant,
    output logic                     timeout_err,
    output logic [ARB_IDXW-1:0]      timeout_port
);

    localparam int                PW     = PORTS * DATAW;
    localparam logic [WDOG_W-1:0] TO_LIM = WDOG_W'(TIMEOUT);

    arb_state_t             state_q, state_d;
    logic [PORTS-1:0]       ack_q, ack_d;
    logic [PW-1:0]          dout_q, dout_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDRW-1:0]       mem_addr_q, mem_addr_d;
    logic [DATAW-1:0]       mem_din_q, mem_din_d;
    logic [ARB_IDXW-1:0]    grant_q, grant_d;
    logic [ARB_IDXW-1:0]    rr_ptr_q, rr_ptr_d;
    logic                   busy_q, busy_d;
    logic                   terr_q, terr_d;
    logic [ARB_IDXW-1:0]    tport_q, tport_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d;

    logic [PORTS-1:0]       pending;
    logic                   pick_found;
    logic [ARB_IDXW-1:0]    pick_idx;
    logic                   mem_done;
    logic [ARB_IDXW-1:0]    ptr_after;
    logic [PORTS-1:0]       ack_flip;
    int                     win_base_a;
    int                     win_base_d;
    int                     gnt_base_d;

    assign pending  = req ^ ack_q;
    assign mem_done = (mem_ack == mem_req_q);

    rr_pick #(.N(PORTS)) u_pick (
        .pending (pending),
        .ptr     (rr_ptr_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Next-state, command latches, watchdog and per-port ack/dout updates.
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        dout_d     = dout_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        terr_d     = terr_q;
        tport_d    = tport_q;
        wdog_d     = wdog_q;

        win_base_a = slice_base(int'(pick_idx), ADDRW);
        win_base_d = slice_base(int'(pick_idx), DATAW);
        gnt_base_d = slice_base(int'(grant_q), DATAW);
        ptr_after  = (int'(grant_q) == PORTS - 1) ? '0 : grant_q + 1'b1;
        ack_flip   = PORTS'(1) << grant_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    mem_we_d   = 1'(we >> pick_idx);
                    mem_addr_d = ADDRW'(addr >> win_base_a);
                    mem_din_d  = DATAW'(din >> win_base_d);
                    grant_d    = pick_idx;
                    mem_req_d  = ~mem_req_q;
                    wdog_d     = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    if (!mem_we_q) begin
                        dout_d = (dout_q & ~(PW'({DATAW{1'b1}}) << gnt_base_d))
                               | (PW'(mem_dout) << gnt_base_d);
                    end
                    ack_d    = ack_q ^ ack_flip;
                    rr_ptr_d = ptr_after;
                    state_d  = ST_IDLE;
                end else if (wdog_q >= TO_LIM) begin
                    // Release the requester; the controller access stays outstanding until DRAIN sees it.
                    ack_d    = ack_q ^ ack_flip;
                    terr_d   = 1'b1;
                    if (!terr_q) begin
                        tport_d = grant_q;
                    end
                    rr_ptr_d = ptr_after;
                    state_d  = ST_DRAIN;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (mem_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register; reset aligns mem_req to mem_ack so nothing looks outstanding.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            dout_q     <= '0;
            mem_req_q  <= mem_ack;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            tport_q    <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
            tport_q    <= tport_d;
            wdog_q     <= wdog_d;
        end
    end

    assign ack          = ack_q;
    assign dout         = dout_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign busy         = busy_q;
    assign grant        = grant_q;
    assign timeout_err  = terr_q;
    assign timeout_port = tport_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int P  = 4;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int TO = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [P-1:0]      req, ack, we;
    logic [P*AW-1:0]   addr;
    logic [P*DW-1:0]   din, dout;
    logic              mem_req, mem_ack, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din, mem_dout;
    logic              busy, timeout_err;
    logic [2:0]        grant, timeout_port;

    sdram_port_arbiter #(.PORTS(P), .ADDRW(AW), .DATAW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .we(we), .addr(addr),
        .din(din), .dout(dout), .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy),
        .grant(grant), .timeout_err(timeout_err), .timeout_port(timeout_port)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- controller model (environment) ----------------
    bit        rst_ack_val = 1'b0;
    bit        ctl_hold    = 1'b0;
    bit        ctl_rand    = 1'b0;
    bit        ctl_fixed   = 1'b0;
    int        ctl_delay   = 1;
    logic [DW-1:0] ctl_data = '0;
    bit        ctl_busy    = 1'b0;
    int        ctl_cnt     = 0;

    initial begin
        mem_ack  = 1'b0;
        mem_dout = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mem_ack  = rst_ack_val;
                ctl_busy = 1'b0;
            end else if (ctl_busy) begin
                if (!ctl_hold) begin
                    ctl_cnt = ctl_cnt - 1;
                    if (ctl_cnt <= 0) begin
                        mem_dout = ctl_fixed ? ctl_data : DW'($urandom);
                        mem_ack  = ~mem_ack;
                        ctl_busy = 1'b0;
                    end
                end
            end else if (mem_req !== mem_ack) begin
                ctl_busy = 1'b1;
                ctl_cnt  = ctl_rand ? int'($urandom_range(1, 13)) : ctl_delay;
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    int            cyc = 0;
    bit            m_valid = 1'b0;
    logic [P-1:0]  m_ack, pend;
    logic [P*DW-1:0] m_dout;
    logic          m_mreq, m_mwe;
    logic [AW-1:0] m_maddr;
    logic [DW-1:0] m_mdin;
    int            m_grant, m_ptr, m_tport, m_issue, win;
    bit            m_inflight, m_orphan, m_terr;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (!reset_n) begin
            m_valid = 1'b1;   m_ack = '0;      m_dout = '0;    m_mreq = mem_ack;
            m_mwe = 1'b0;     m_maddr = '0;    m_mdin = '0;    m_grant = 0;
            m_ptr = 0;        m_inflight = 0;  m_orphan = 0;   m_terr = 0;
            m_tport = 0;
        end else if (m_inflight) begin
            if (mem_ack == m_mreq) begin
                if (!m_mwe) m_dout[m_grant*DW +: DW] = mem_dout;
                m_ack[m_grant] = ~m_ack[m_grant];
                m_ptr = (m_grant + 1) % P;
                m_inflight = 0;
            end else if (cyc - m_issue == TO + 1) begin
                m_ack[m_grant] = ~m_ack[m_grant];
                if (!m_terr) m_tport = m_grant;
                m_terr = 1;
                m_ptr = (m_grant + 1) % P;
                m_inflight = 0;
                m_orphan = 1;
            end
        end else if (m_orphan) begin
            if (mem_ack == m_mreq) m_orphan = 0;
        end else begin
            pend = req ^ m_ack;
            win  = -1;
            for (int k = 0; k < P; k++) begin
                if (win < 0 && pend[(m_ptr + k) % P]) win = (m_ptr + k) % P;
            end
            if (win >= 0) begin
                m_grant = win;
                m_mwe   = we[win];
                m_maddr = addr[win*AW +: AW];
                m_mdin  = din[win*DW +: DW];
                m_mreq  = ~m_mreq;
                m_inflight = 1;
                m_issue = cyc;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    int   gq[$];
    int   gc[$];
    logic prev_mreq = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("ack",          64'(ack),          64'(m_ack));
            chk("dout",         64'(dout),         64'(m_dout));
            chk("mem_req",      64'(mem_req),      64'(m_mreq));
            chk("mem_we",       64'(mem_we),       64'(m_mwe));
            chk("mem_addr",     64'(mem_addr),     64'(m_maddr));
            chk("mem_din",      64'(mem_din),      64'(m_mdin));
            chk("busy",         64'(busy),         64'(m_inflight | m_orphan));
            chk("grant",        64'(grant),        64'(m_grant));
            chk("timeout_err",  64'(timeout_err),  64'(m_terr));
            chk("timeout_port", 64'(timeout_port), 64'(m_tport));
            if (reset_n && mem_req !== prev_mreq) begin
                gq.push_back(int'(grant));
                gc.push_back(cyc);
            end
        end
        prev_mreq = mem_req;
    end

    // ---------------- directed helpers ----------------
    task automatic at_edge(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit v);
        @(negedge clk);
        reset_n = 1'b0; rst_ack_val = v;
        req = '0; we = '0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (!(req == ack && !busy) && t < 500) begin at_edge(1); t++; end
        chk(nm, 64'(t < 500), 64'(1));
    endtask

    int exp_order[6] = '{0, 1, 2, 3, 0, 3};

    initial begin
        int t;
        reset_n = 1'b0; req = '0; we = '0; addr = '0; din = '0;

        // reset state with mem_ack low
        ctl_fixed = 1; ctl_data = 16'hBEEF; ctl_delay = 6;
        do_reset(1'b0);
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_terr", 64'(timeout_err), 64'(0));

        // single read on port 2
        we[2] = 1'b0; addr[2*AW +: AW] = 22'h1234; req[2] = 1'b1;
        at_edge(1);
        chk("rd_issue_mem_req", 64'(mem_req), 64'(1));
        chk("rd_issue_addr", 64'(mem_addr), 64'(22'h1234));
        chk("rd_issue_busy", 64'(busy), 64'(1));
        chk("rd_issue_grant", 64'(grant), 64'(2));
        at_edge(6);
        chk("rd_ack_edge7", 64'(ack), 64'(0));
        at_edge(1);
        chk("rd_ack_edge8", 64'(ack), 64'(4'b0100));
        chk("rd_dout2", 64'(dout[2*DW +: DW]), 64'(16'hBEEF));
        chk("rd_busy_fall", 64'(busy), 64'(0));

        // fairness
        do_reset(1'b0);
        ctl_fixed = 0; ctl_delay = 2;
        gq.delete(); gc.delete();
        req = 4'hF;
        t = 0;
        while (!(grant == 3'd3 && busy) && t < 100) begin at_edge(1); t++; end
        chk("fair_reach_p3", 64'(t < 100), 64'(1));
        @(negedge clk); req[0] = ~req[0];
        t = 0;
        while (!(ack[3]) && t < 100) begin at_edge(1); t++; end
        chk("fair_ack3", 64'(t < 100), 64'(1));
        @(negedge clk); req[3] = ~req[3];
        t = 0;
        while (gq.size() < 6 && t < 100) begin at_edge(1); t++; end
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair_order%0d", i), 64'((i < gq.size()) ? gq[i] : -1), 64'(exp_order[i]));
        end
        chk("fair_b2b_gap", 64'((gc.size() > 1) ? gc[1] - gc[0] : -1), 64'(4));
        wait_idle("fair_idle");

        // write on port 1
        do_reset(1'b0);
        ctl_fixed = 1; ctl_data = 16'h7777; ctl_delay = 3;
        we[1] = 1'b1; addr[1*AW +: AW] = 22'h3FFFFF; din[1*DW +: DW] = 16'h55AA; req[1] = 1'b1;
        at_edge(1);
        chk("wr_we", 64'(mem_we), 64'(1));
        chk("wr_din", 64'(mem_din), 64'(16'h55AA));
        chk("wr_addr", 64'(mem_addr), 64'(22'h3FFFFF));
        t = 0;
        while (!ack[1] && t < 50) begin at_edge(1); t++; end
        chk("wr_ack", 64'(t < 50), 64'(1));
        chk("wr_dout_kept", 64'(dout), 64'(0));

        // watchdog on port 3
        @(negedge clk);
        ctl_hold = 1; ctl_delay = 1; ctl_data = 16'h1111;
        we[3] = 1'b0; req[3] = 1'b1;
        at_edge(1);
        chk("wd_issue", 64'(mem_req), 64'(0));
        at_edge(10);
        chk("wd_ack3_edge11", 64'(ack[3]), 64'(0));
        chk("wd_terr_edge11", 64'(timeout_err), 64'(0));
        at_edge(1);
        chk("wd_ack3_edge12", 64'(ack[3]), 64'(1));
        chk("wd_terr", 64'(timeout_err), 64'(1));
        chk("wd_tport", 64'(timeout_port), 64'(3));
        chk("wd_busy_drain", 64'(busy), 64'(1));
        @(negedge clk); we[0] = 1'b0; req[0] = 1'b1;
        at_edge(6);
        chk("wd_blocked_mreq", 64'(mem_req), 64'(0));
        chk("wd_blocked_ack0", 64'(ack[0]), 64'(0));
        @(negedge clk); ctl_hold = 0;
        t = 0;
        while (!ack[0] && t < 50) begin at_edge(1); t++; end
        chk("wd_p0_done", 64'(t < 50), 64'(1));
        chk("wd_late_discard", 64'(dout[3*DW +: DW]), 64'(0));
        chk("wd_p0_data", 64'(dout[0 +: DW]), 64'(16'h1111));

        // reset with mem_ack high
        do_reset(1'b1);
        chk("rst1_mem_req", 64'(mem_req), 64'(1));
        chk("rst1_terr", 64'(timeout_err), 64'(0));
        chk("rst1_tport", 64'(timeout_port), 64'(0));
        we[0] = 1'b0; req[0] = 1'b1;
        at_edge(1);
        chk("rst1_first_issue", 64'(mem_req), 64'(0));
        wait_idle("rst1_idle");

        // reset mid-access
        do_reset(1'b0);
        ctl_hold = 1;
        we[1] = 1'b1; addr[1*AW +: AW] = 22'h2AAAA; din[1*DW +: DW] = 16'hC3C3; req[1] = 1'b1;
        at_edge(3);
        chk("mid_busy", 64'(busy), 64'(1));
        @(negedge clk);
        reset_n = 1'b0; rst_ack_val = 1'b0; req = '0; we = '0; addr = '0; din = '0;
        at_edge(1);
        chk("mid_ack", 64'(ack), 64'(0));
        chk("mid_busy0", 64'(busy), 64'(0));
        chk("mid_mem_req", 64'(mem_req), 64'(0));
        chk("mid_mem_we", 64'(mem_we), 64'(0));
        chk("mid_mem_addr", 64'(mem_addr), 64'(0));
        chk("mid_mem_din", 64'(mem_din), 64'(0));
        chk("mid_grant", 64'(grant), 64'(0));
        @(negedge clk); ctl_hold = 0; reset_n = 1'b1;

        // randomized traffic
        do_reset(1'b0);
        ctl_rand = 1; ctl_fixed = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            for (int i = 0; i < P; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if (req[i] == ack[i]) begin
                        we[i] = 1'($urandom);
                        addr[i*AW +: AW] = AW'($urandom);
                        din[i*DW +: DW]  = DW'($urandom);
                        req[i] = ~req[i];
                    end else if ($urandom_range(0, 49) == 0) begin
                        req[i] = ~req[i];
                    end
                end
            end
        end
        wait_idle("rand_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
